// File: rtl/enemy_pool_pkg.sv
// Shared record layout, type codes and spawn defaults for the enemy table.
package enemy_pool_pkg;

   localparam int TYPEW = 4;
   localparam int XW    = 10;
   localparam int YW    = 10;
   localparam int WW    = 10;
   localparam int HW    = 10;

   localparam int TYPE_LSB = 0;
   localparam int X_LSB    = TYPE_LSB + TYPEW;
   localparam int Y_LSB    = X_LSB + XW;
   localparam int W_LSB    = Y_LSB + YW;
   localparam int H_LSB    = W_LSB + WW;
   localparam int REC_W    = H_LSB + HW;

   localparam int SCREEN_W = 640;
   localparam int GROUND_Y = 400;
   localparam int AIR_Y    = 340;
   localparam int GROUND_W = 20;
   localparam int GROUND_H = 40;
   localparam int AIR_W    = 40;
   localparam int AIR_H    = 20;

   typedef enum logic [TYPEW-1:0] {
      EMPTY  = 4'd0,
      GROUND = 4'd1,
      AIR    = 4'd2
   } enemy_type_e;

   // Declared MSB-first so the type field lands in the low bits.
   typedef struct packed {
      logic [HW-1:0] h;
      logic [WW-1:0] w;
      logic [YW-1:0] y;
      logic [XW-1:0] x;
      enemy_type_e   kind;
   } enemy_rec_t;

   function automatic enemy_rec_t spawn_rec(input logic air);
      enemy_rec_t r;
      r.kind = air ? AIR : GROUND;
      r.x    = XW'(SCREEN_W);
      r.y    = air ? YW'(AIR_Y) : YW'(GROUND_Y);
      r.w    = air ? WW'(AIR_W) : WW'(GROUND_W);
      r.h    = air ? HW'(AIR_H) : HW'(GROUND_H);
      return r;
   endfunction

endpackage

// File: rtl/enemy_pool_slot_alloc.sv
// Priority encoder: lowest-index slot whose type field is empty.
module enemy_slot_alloc
   import enemy_pool_pkg::*;
#(
   parameter int SLOTS = 9,
   parameter int IDXW  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic [SLOTS*TYPEW-1:0] types,
   output logic [IDXW-1:0]        free_idx,
   output logic                   any_free
);

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         if (!any_free && types[i*TYPEW +: TYPEW] == '0) begin
            any_free = 1'b1;
            free_idx = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/enemy_pool.sv
// Enemy record table: spawns, moves left on frame ticks, frees off-screen enemies.
module enemy_pool
   import enemy_pool_pkg::*;
#(
   parameter int SLOTS   = 9,
   parameter int MIN_GAP = 30,
   parameter int SPDW    = 4
) (
   input  logic                         clk3,
   input  logic                         rst,
   input  logic                         tick,
   input  logic                         freeze,
   input  logic                         clear,
   input  logic [SPDW-1:0]              speed,
   input  logic                         spawn_valid,
   input  logic                         spawn_kind,
   output logic                         spawn_ready,
   output logic [SLOTS*REC_W-1:0]       enemy_table,
   output logic [$clog2(SLOTS+1)-1:0]   active_cnt,
   output logic                         pass_pulse,
   output logic [1:0]                   pass_cnt
);

   localparam int IDXW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CNTW = $clog2(SLOTS + 1);
   localparam int GAPW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   enemy_rec_t            rec_q [SLOTS];
   enemy_rec_t            rec_d [SLOTS];
   logic [SLOTS*TYPEW-1:0] types;
   logic [IDXW-1:0]       free_idx;
   logic                  any_free;
   logic [GAPW-1:0]       gap_q, gap_d;
   logic [CNTW-1:0]       npass, acnt_d;
   logic [XW-1:0]         speed_x;
   logic                  step, fire;

   always_comb begin
      types       = '0;
      enemy_table = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         types[i*TYPEW +: TYPEW]       = rec_q[i].kind;
         enemy_table[i*REC_W +: REC_W] = rec_q[i];
      end
   end

   enemy_slot_alloc #(.SLOTS(SLOTS), .IDXW(IDXW)) u_alloc (
      .types    (types),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign step        = tick && !freeze;
   assign spawn_ready = any_free && (gap_q == '0) && !clear;
   assign fire        = spawn_valid && spawn_ready;
   assign speed_x     = XW'(speed);

   // The spawned slot was empty pre-cycle, so movement never touches it this edge.
   always_comb begin
      npass  = '0;
      acnt_d = '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
         rec_d[i] = rec_q[i];
         if (step && rec_q[i].kind != EMPTY) begin
            if (rec_q[i].x < speed_x || rec_q[i].x == '0) begin
               rec_d[i].kind = EMPTY;
               npass         = npass + CNTW'(1);
            end else begin
               rec_d[i].x = rec_q[i].x - speed_x;
            end
         end
         if (fire && free_idx == IDXW'(i))
            rec_d[i] = spawn_rec(spawn_kind);
         acnt_d = acnt_d + CNTW'(rec_d[i].kind != EMPTY);
      end
   end

   always_comb begin
      gap_d = gap_q;
      if (fire)
         gap_d = GAPW'(MIN_GAP);
      else if (step && gap_q != '0)
         gap_d = gap_q - GAPW'(1);
   end

   always_ff @(posedge clk3) begin
      if (rst || clear) begin
         for (int unsigned i = 0; i < SLOTS; i++)
            rec_q[i] <= '0;
         gap_q      <= rst ? '0 : GAPW'(MIN_GAP);
         active_cnt <= '0;
         pass_pulse <= 1'b0;
         pass_cnt   <= '0;
      end else begin
         rec_q      <= rec_d;
         gap_q      <= gap_d;
         active_cnt <= acnt_d;
         pass_pulse <= (npass != '0);
         pass_cnt   <= (npass > CNTW'(3)) ? 2'd3 : npass[1:0];
      end
   end

endmodule

// File: tb/tb_enemy_pool.sv
// Directed bench for enemy_pool: spawn gap, movement, passes, freeze, clear, full table.
module tb_enemy_pool;

   localparam int SLOTS = 9;
   localparam int RW    = 44;

   logic              clk3 = 1'b0;
   logic              rst, tick, freeze, clear, spawn_valid, spawn_kind;
   logic [3:0]        speed;
   logic              spawn_ready;
   logic [SLOTS*RW-1:0] enemy_table;
   logic [3:0]        active_cnt;
   logic              pass_pulse;
   logic [1:0]        pass_cnt;

   int total = 0;
   int bad   = 0;

   localparam logic [RW-1:0] G640 = {10'd40, 10'd20, 10'd400, 10'd640, 4'd1};
   localparam logic [RW-1:0] A640 = {10'd20, 10'd40, 10'd340, 10'd640, 4'd2};

   enemy_pool #(.SLOTS(9), .MIN_GAP(30), .SPDW(4)) dut (
      .clk3        (clk3),
      .rst         (rst),
      .tick        (tick),
      .freeze      (freeze),
      .clear       (clear),
      .speed       (speed),
      .spawn_valid (spawn_valid),
      .spawn_kind  (spawn_kind),
      .spawn_ready (spawn_ready),
      .enemy_table (enemy_table),
      .active_cnt  (active_cnt),
      .pass_pulse  (pass_pulse),
      .pass_cnt    (pass_cnt)
   );

   always #5 clk3 = ~clk3;

   function automatic logic [RW-1:0] slot(input int i);
      return enemy_table[i*RW +: RW];
   endfunction

   function automatic logic [3:0] stype(input int i);
      logic [RW-1:0] s;
      s = slot(i);
      return s[3:0];
   endfunction

   function automatic logic [9:0] sx(input int i);
      logic [RW-1:0] s;
      s = slot(i);
      return s[13:4];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk3);
      #1;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) step();
      tick = 1'b0;
   endtask

   task automatic spawn_one();
      spawn_valid = 1'b1;
      step();
      spawn_valid = 1'b0;
   endtask

   int fill_idx [8] = '{0, 1, 2, 4, 5, 6, 7, 8};

   initial begin
      rst = 1'b1; tick = 1'b0; freeze = 1'b0; clear = 1'b0;
      spawn_valid = 1'b0; spawn_kind = 1'b0; speed = 4'd0;
      step(); step();
      rst = 1'b0;
      chk("rst_table_nonzero", |enemy_table, 0);
      chk("rst_active", active_cnt, 0);
      chk("rst_pulse", pass_pulse, 0);
      chk("rst_cnt", pass_cnt, 0);
      chk("rst_ready", spawn_ready, 1);

      // first spawn and the 30-tick gap
      spawn_valid = 1'b1;
      #1 chk("ready_before_spawn", spawn_ready, 1);
      step();
      spawn_valid = 1'b0;
      chk("slot0_ground", slot(0), G640);
      chk("active_one", active_cnt, 1);
      chk("ready_after_spawn", spawn_ready, 0);
      tick = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk($sformatf("gap_tick%0d", k), spawn_ready, (k == 30));
      end
      tick = 1'b0;
      chk("speed0_x", sx(0), 640);

      // movement down to 10, then 6, 2, freed
      speed = 4'd15;
      ticks(42);
      chk("x_at_10", sx(0), 10);
      speed = 4'd4;
      tick = 1'b1;
      step(); chk("x_at_6", sx(0), 6);
      step(); chk("x_at_2", sx(0), 2);
      chk("no_pulse_yet", pass_pulse, 0);
      step();
      tick = 1'b0;
      chk("freed_type", stype(0), 0);
      chk("pass_pulse1", pass_pulse, 1);
      chk("pass_cnt1", pass_cnt, 1);
      chk("active_zero", active_cnt, 0);
      step();
      chk("pulse_drop", pass_pulse, 0);
      chk("cnt_drop", pass_cnt, 0);

      // spawn on the same edge as a tick
      speed = 4'd0;
      spawn_one();
      ticks(30);
      chk("ready_for_air", spawn_ready, 1);
      speed = 4'd5; tick = 1'b1; spawn_valid = 1'b1; spawn_kind = 1'b1;
      step();
      tick = 1'b0; spawn_valid = 1'b0; spawn_kind = 1'b0;
      chk("air_unmoved", slot(1), A640);
      chk("old_moved", sx(0), 635);
      chk("active_two", active_cnt, 2);

      // freeze holds table and gap counter
      freeze = 1'b1; tick = 1'b1;
      repeat (4) step();
      freeze = 1'b0; tick = 1'b0;
      chk("freeze_x", sx(0), 635);
      chk("freeze_ready", spawn_ready, 0);
      speed = 4'd0;
      tick = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk($sformatf("frz_gap%0d", k), spawn_ready, (k == 30));
      end
      tick = 1'b0;

      // clear wipes and reloads the gap
      clear = 1'b1;
      #1 chk("ready_in_clear", spawn_ready, 0);
      step();
      clear = 1'b0;
      chk("clear_table_nonzero", |enemy_table, 0);
      chk("clear_active", active_cnt, 0);
      chk("clear_ready", spawn_ready, 0);
      tick = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         step();
         chk($sformatf("clr_gap%0d", k), spawn_ready, (k == 30));
      end
      tick = 1'b0;

      // three ground enemies, moved to x=40, then a fourth at 640
      for (int s = 0; s < 3; s++) begin
         spawn_one();
         ticks(30);
      end
      speed = 4'd15;
      ticks(40);
      chk("trio_x40", sx(0), 40);
      chk("ready_slot3", spawn_ready, 1);
      spawn_one();
      chk("slot3_new", slot(3), G640);
      ticks(3);
      chk("trio_freed_cnt", pass_cnt, 3);
      chk("trio_pulse", pass_pulse, 1);
      chk("trio_active", active_cnt, 1);
      chk("slot3_x595", sx(3), 595);
      step();
      chk("trio_pulse_drop", pass_pulse, 0);

      // fill remaining slots lowest-first
      speed = 4'd0;
      ticks(27);
      for (int s = 0; s < 8; s++) begin
         chk($sformatf("fill_ready%0d", s), spawn_ready, 1);
         spawn_one();
         chk($sformatf("fill_slot%0d", fill_idx[s]), slot(fill_idx[s]), G640);
         ticks(30);
      end
      chk("full_active", active_cnt, 9);
      chk("full_ready", spawn_ready, 0);
      spawn_valid = 1'b1;
      repeat (3) step();
      chk("full_hold_active", active_cnt, 9);
      chk("full_no_overwrite", slot(8), G640);
      chk("full_slot3_kept", sx(3), 595);

      // free slot 3 by movement while the request is held
      speed = 4'd15;
      tick = 1'b1;
      repeat (39) step();
      chk("slot3_x10", sx(3), 10);
      step();
      tick = 1'b0;
      chk("slot3_freed", stype(3), 0);
      chk("slot3_pass", pass_cnt, 1);
      chk("slot4_x40", sx(4), 40);
      chk("active_eight", active_cnt, 8);
      chk("ready_refill", spawn_ready, 1);
      step();
      spawn_valid = 1'b0;
      chk("refill_slot3", slot(3), G640);
      chk("refill_active", active_cnt, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
